uart_rx_fifo: RTL and testbench

Parametrised successor to the fixed 8N1 / 9600-baud serial receiver. It adds:
- configurable clock, baud, data width, parity and stop bits;
- input synchronisation and 3-sample majority voting;
- false-start rejection;
- framing and parity error detection;
- a small receive FIFO with overrun reporting.

It sits between the `RXD` pin and the concentrator's byte consumer. It keeps the `next`/`unload` pop handshake.

---
 rtl/uart_rx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 16x-oversampling UART receiver with majority-voted bit decisions, framing and
// parity checking, and a small receive FIFO drained through the next/unload handshake.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              RXD,
  input  logic                              next,
  output logic [DATA_BITS-1:0]              PAR,
  output logic                              parity_err,
  output logic                              frame_err,
  output logic                              ready,
  output logic                              unload,
  output logic                              overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = $clog2(FIFO_DEPTH + 1);
  localparam int EW  = DATA_BITS + 2;

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic [NW-1:0] FULL     = NW'(FIFO_DEPTH);
  localparam logic          PAR_EXP  = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_d;
  logic                 rx_meta, rxs;
  logic [CW-1:0]        div_cnt;
  logic                 tick;
  logic [3:0]           ph;
  logic                 s7, s8;
  logic                 bit_val, decide, ph_end;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_cn;
  logic                 stop_cn, last_stop;
  logic                 perr, ferr;
  logic                 go_idle, frame_done;
  logic [EW-1:0]        entry;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, drop;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rxs     <= rx_meta;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else        div_cnt <= tick ? '0 : div_cnt + CW'(1);
  end

  assign decide    = tick && (ph == 4'd9);
  assign ph_end    = tick && (ph == 4'd15);
  assign bit_val   = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign last_stop = (STOP_BITS == 1) || stop_cn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state;
    go_idle    = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE:   if (!rxs) state_d = S_START;
      S_START: begin
        if (decide && bit_val) begin
          state_d = S_IDLE;
          go_idle = 1'b1;
        end else if (ph_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA:   if (ph_end && bit_cn == BIT_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (ph_end) state_d = S_STOP;
      S_STOP: begin
        // Leave on the last stop bit's decision so a following start edge is never missed.
        if (decide && last_stop) begin
          state_d    = S_IDLE;
          go_idle    = 1'b1;
          frame_done = 1'b1;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph      <= '0;
      s7      <= 1'b1;
      s8      <= 1'b1;
      shreg   <= '0;
      bit_cn  <= '0;
      stop_cn <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      if (state == S_IDLE || go_idle) ph <= '0;
      else if (tick)                  ph <= ph + 4'd1;
      if (tick && ph == 4'd7) s7 <= rxs;
      if (tick && ph == 4'd8) s8 <= rxs;
      case (state)
        S_IDLE: begin
          bit_cn  <= '0;
          stop_cn <= 1'b0;
          perr    <= 1'b0;
          ferr    <= 1'b0;
        end
        S_DATA: begin
          if (decide) shreg  <= {bit_val, shreg[DATA_BITS-1:1]};
          if (ph_end) bit_cn <= bit_cn + 4'd1;
        end
        S_PARITY: if (decide) perr <= ((^shreg) ^ bit_val) != PAR_EXP;
        S_STOP: begin
          if (decide && !bit_val) ferr    <= 1'b1;
          if (ph_end)             stop_cn <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The current stop decision is folded in directly; ferr only holds earlier stop bits.
  assign entry  = {ferr | ~bit_val, perr, shreg};
  assign ready  = (count != '0);
  assign unload = ready & next;
  assign push   = frame_done && (count != FULL || unload);
  assign drop   = frame_done && !push;

  // NOTE: the FIFO storage is reset too, so the head outputs read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (unload) rd_ptr <= rd_ptr + AW'(1);
      case ({push, unload})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: ;
      endcase
      if (drop)        overrun <= 1'b1;
      else if (unload) overrun <= 1'b0;
    end
  end

  assign {frame_err, parity_err, PAR} = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 receiver and an 8E1 receiver, both at
// 160 clocks per bit, with frames aligned to the free-running tick for exact timing.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n, rxd, rxd_p, next, next_p;
  logic [7:0] par, par_p;
  logic       parity_err, frame_err, ready, unload, overrun;
  logic       parity_err_p, frame_err_p, ready_p, unload_p, overrun_p;
  logic [2:0] count, count_p;
  int         checks = 0;
  int         failures = 0;
  int         edge_cnt;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_HZ(1600000), .BAUD(10000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .RXD(rxd), .next(next), .PAR(par),
    .parity_err(parity_err), .frame_err(frame_err), .ready(ready),
    .unload(unload), .overrun(overrun), .count(count));

  uart_rx_fifo #(.CLK_HZ(1600000), .BAUD(10000), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
    .clk(clk), .rst_n(rst_n), .RXD(rxd_p), .next(next_p), .PAR(par_p),
    .parity_err(parity_err_p), .frame_err(frame_err_p), .ready(ready_p),
    .unload(unload_p), .overrun(overrun_p), .count(count_p));

  // Mirrors the divider's free-running phase: ticks land on edges where edge_cnt % 10 == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Drives one frame starting just after a tick edge; rise_j is the clock at which count first changed.
  task automatic send_frame(input bit on_p, input logic [7:0] data, input bit has_par,
                            input logic par_bit, input logic stop_val, input int glitch_j,
                            output int rise_j);
    logic [10:0] bits;
    logic [2:0]  c0;
    logic        v;
    int          nb;
    bits = {1'b1, 1'b1, stop_val, data, 1'b0};
    nb   = 10;
    if (has_par) begin
      bits = {1'b1, stop_val, par_bit, data, 1'b0};
      nb   = 11;
    end
    for (int w = 0; w < 10 && (edge_cnt % 10) != 0; w++) @(negedge clk);
    c0     = on_p ? count_p : count;
    rise_j = -1;
    for (int j = 0; j < nb * 160; j++) begin
      v = bits[j / 160];
      if (j == glitch_j) v = 1'b0;
      if (on_p) rxd_p = v; else rxd = v;
      @(negedge clk);
      if (rise_j < 0 && (on_p ? count_p : count) != c0) rise_j = j + 1;
    end
    if (on_p) rxd_p = 1'b1; else rxd = 1'b1;
  endtask

  task automatic pulse_next(input bit on_p, output logic unl);
    if (on_p) next_p = 1'b1; else next = 1'b1;
    #1 unl = on_p ? unload_p : unload;
    @(negedge clk);
    if (on_p) next_p = 1'b0; else next = 1'b0;
  endtask

  task automatic test_reset;
    rxd = 1'b1; rxd_p = 1'b1; next = 1'b0; next_p = 1'b0; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (par !== 8'h00) begin failures++; $display("FAIL reset_par got=%h exp=00", par); end
    checks++; if ({ready, unload, overrun, frame_err, parity_err} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {ready, unload, overrun, frame_err, parity_err}); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_idle_ready got=%b exp=0", ready); end
  endtask

  task automatic test_basic;
    int rj; logic unl;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, rj);
    checks++; if (rj != 1540) begin failures++; $display("FAIL basic_push_time got=%0d exp=1540", rj); end
    checks++; if (ready !== 1'b1 || count !== 3'd1) begin failures++; $display("FAIL basic_ready got=%b/%0d exp=1/1", ready, count); end
    checks++; if (par !== 8'hA5) begin failures++; $display("FAIL basic_par got=%h exp=a5", par); end
    checks++; if ({frame_err, parity_err} !== 2'b00) begin failures++; $display("FAIL basic_errs got=%b exp=00", {frame_err, parity_err}); end
    pulse_next(1'b0, unl);
    checks++; if (unl !== 1'b1) begin failures++; $display("FAIL basic_unload got=%b exp=1", unl); end
    #1;
    checks++; if (unload !== 1'b0) begin failures++; $display("FAIL basic_unload_end got=%b exp=0", unload); end
    checks++; if (ready !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL basic_popped got=%b/%0d exp=0/0", ready, count); end
    @(negedge clk);
  endtask

  task automatic test_false_start;
    int rj; logic unl;
    for (int w = 0; w < 10 && (edge_cnt % 10) != 0; w++) @(negedge clk);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    checks++; if (ready !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL false_start got=%b/%0d exp=0/0", ready, count); end
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, -1, rj);
    checks++; if (par !== 8'h3C || count !== 3'd1) begin failures++; $display("FAIL after_false_start got=%h/%0d exp=3c/1", par, count); end
    pulse_next(1'b0, unl);
  endtask

  task automatic test_parity;
    int rj; logic unl;
    send_frame(1'b1, 8'h37, 1'b1, 1'b0, 1'b1, -1, rj);
    checks++; if (rj != 1700) begin failures++; $display("FAIL parity_push_time got=%0d exp=1700", rj); end
    checks++; if (par_p !== 8'h37) begin failures++; $display("FAIL parity_bad_par got=%h exp=37", par_p); end
    checks++; if ({frame_err_p, parity_err_p} !== 2'b01) begin failures++; $display("FAIL parity_bad_errs got=%b exp=01", {frame_err_p, parity_err_p}); end
    pulse_next(1'b1, unl);
    send_frame(1'b1, 8'h37, 1'b1, 1'b1, 1'b1, -1, rj);
    checks++; if (par_p !== 8'h37 || count_p !== 3'd1) begin failures++; $display("FAIL parity_good_par got=%h/%0d exp=37/1", par_p, count_p); end
    checks++; if ({frame_err_p, parity_err_p} !== 2'b00) begin failures++; $display("FAIL parity_good_errs got=%b exp=00", {frame_err_p, parity_err_p}); end
    pulse_next(1'b1, unl);
  endtask

  task automatic test_frame_glitch;
    int rj; logic unl;
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0, -1, rj);
    checks++; if (par !== 8'h81) begin failures++; $display("FAIL frame_par got=%h exp=81", par); end
    checks++; if ({frame_err, parity_err} !== 2'b10) begin failures++; $display("FAIL frame_errs got=%b exp=10", {frame_err, parity_err}); end
    repeat (400) @(negedge clk);
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL frame_no_phantom got=%0d exp=1", count); end
    pulse_next(1'b0, unl);
    // One-clock low pulse timed to land on the ph=8 sample of data bit 7.
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1367, rj);
    checks++; if (par !== 8'h81 || frame_err !== 1'b0) begin failures++; $display("FAIL glitch_vote got=%h/%b exp=81/0", par, frame_err); end
    pulse_next(1'b0, unl);
  endtask

  task automatic test_back_to_back;
    int rj; logic unl;
    for (int i = 1; i <= 5; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1, -1, rj);
    checks++; if (count !== 3'd4 || overrun !== 1'b1) begin failures++; $display("FAIL overrun_state got=%0d/%b exp=4/1", count, overrun); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (par !== 8'(i)) begin failures++; $display("FAIL drain_%0d got=%h exp=%h", i, par, 8'(i)); end
      pulse_next(1'b0, unl);
      if (i == 1) begin
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
      end
    end
    checks++; if (count !== 3'd0 || ready !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0d/%b exp=0/0", count, ready); end
  endtask

  task automatic test_reset_mid_frame;
    int rj;
    logic [9:0] bits;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, -1, rj);
    bits = {1'b1, 8'h55, 1'b0};
    for (int w = 0; w < 10 && (edge_cnt % 10) != 0; w++) @(negedge clk);
    for (int j = 0; j < 4 * 160 + 80; j++) begin
      rxd = bits[j / 160];
      @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (par !== 8'h00 || count !== 3'd0) begin failures++; $display("FAIL midreset_state got=%h/%0d exp=00/0", par, count); end
    checks++; if ({ready, overrun, frame_err, parity_err} !== 4'b0) begin failures++; $display("FAIL midreset_flags got=%b exp=0000", {ready, overrun, frame_err, parity_err}); end
    rxd = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, -1, rj);
    checks++; if (par !== 8'hC3 || count !== 3'd1) begin failures++; $display("FAIL after_reset got=%h/%0d exp=c3/1", par, count); end
    checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin failures++; $display("FAIL after_reset_errs got=%b exp=000", {frame_err, parity_err, overrun}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_parity();
    test_frame_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
